// File: rtl/bitmap_pkg.sv
// Shared definitions for the bitmap address stream: edge-mode encoding
// and the width helper for the in-word pixel select.
package bitmap_pkg;

    // Edge handling applied independently to each axis. Encoding 3 behaves
    // like clip so that every value of the 2-bit mode field is defined.
    typedef enum logic [1:0] {
        EDGE_CLIP     = 2'd0,
        EDGE_WRAP     = 2'd1,
        EDGE_CLAMP    = 2'd2,
        EDGE_CLIP_ALT = 2'd3
    } edge_mode_t;

    // Width of the pixel-select field; at least one bit even when a word
    // holds a single pixel.
    function automatic int sel_width(input int ppw);
        int lg;
        lg = $clog2(ppw);
        return (lg < 1) ? 1 : lg;
    endfunction

endpackage

// File: rtl/bitmap_edge.sv
// Per-axis edge handling: maps a signed coordinate into [0, size) using
// clip, wrap or clamp, and flags coordinates that cannot be mapped.
module bitmap_edge
    import bitmap_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic signed [CORDW:0]   a,
    input  logic signed [CORDW-1:0] size,
    input  edge_mode_t              mode,
    output logic        [CORDW-1:0] v,
    output logic                    clip
);

    // Two extra bits hold both -size and 2*size without overflow.
    localparam int EW = CORDW + 2;
    localparam logic signed [EW-1:0] ONE = 1;

    logic signed [EW-1:0] av;
    logic signed [EW-1:0] sz;
    logic signed [EW-1:0] sz2;

    assign av  = EW'(a);
    assign sz  = EW'(size);
    assign sz2 = sz + sz;

    // Saturate a value into [0, lim-1].
    function automatic logic [CORDW-1:0] sat_range(
        input logic signed [EW-1:0] val,
        input logic signed [EW-1:0] lim
    );
        if (val[EW-1])
            return '0;
        else if (val >= lim)
            return CORDW'(lim - ONE);
        else
            return CORDW'(val);
    endfunction

    // Select the mapped coordinate and clip flag for the current mode.
    always_comb begin
        v    = '0;
        clip = 1'b0;
        case (mode)
            EDGE_WRAP: begin
                // A single add/subtract of size only covers [-size, 2*size).
                if ((av < -sz) || (av >= sz2))
                    clip = 1'b1;
                else if (av[EW-1])
                    v = CORDW'(av + sz);
                else if (av >= sz)
                    v = CORDW'(av - sz);
                else
                    v = CORDW'(av);
            end
            EDGE_CLAMP: begin
                v = sat_range(av, sz);
            end
            default: begin
                if (av[EW-1] || (av >= sz))
                    clip = 1'b1;
                else
                    v = CORDW'(av);
            end
        endcase
    end

endmodule

// File: rtl/bitmap_addr_stream.sv
// Bitmap address stream: converts (x+offx, y+offy) requests into a word
// address and in-word pixel select through a 3-stage globally stalled
// valid/ready pipeline. Geometry is captured with each request so it may
// change freely between requests.
module bitmap_addr_stream
    import bitmap_pkg::*;
#(
    parameter  int CORDW = 16,
    parameter  int ADDRW = 24,
    parameter  int PIXW  = 4,
    parameter  int WORDW = 32,
    parameter  int TAGW  = 8,
    localparam int SELW  = sel_width(WORDW / PIXW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] bmpw,
    input  logic signed [CORDW-1:0] bmph,
    input  logic        [ADDRW-1:0] base,
    input  logic        [1:0]       mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic signed [CORDW-1:0] offx,
    input  logic signed [CORDW-1:0] offy,
    input  logic        [TAGW-1:0]  in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [ADDRW-1:0] addr,
    output logic        [SELW-1:0]  sel,
    output logic                    clip,
    output logic        [TAGW-1:0]  out_tag
);

    localparam int PPW   = WORDW / PIXW;
    localparam int SHIFT = $clog2(PPW);
    localparam int PW    = ADDRW + SELW;
    localparam logic [SELW-1:0] SEL_MASK = SELW'(PPW - 1);

    // Global stall: the whole pipe moves whenever the output slot is free.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1 registers: offset coordinates plus captured geometry.
    logic                    vld_p0;
    logic signed [CORDW:0]   ax_p0;
    logic signed [CORDW:0]   ay_p0;
    logic signed [CORDW-1:0] bmpw_p0;
    logic signed [CORDW-1:0] bmph_p0;
    logic        [ADDRW-1:0] base_p0;
    edge_mode_t              mode_p0;
    logic        [TAGW-1:0]  tag_p0;

    // Stage 2 registers: linear pixel index and combined clip flag.
    logic                    vld_p1;
    logic        [PW-1:0]    p_p1;
    logic                    clip_p1;
    logic        [ADDRW-1:0] base_p1;
    logic        [TAGW-1:0]  tag_p1;

    // Edge-mapped coordinates feeding the stage-2 multiply.
    logic [CORDW-1:0] ex;
    logic [CORDW-1:0] ey;
    logic             clip_x;
    logic             clip_y;

    bitmap_edge #(
        .CORDW (CORDW)
    ) u_edge_x (
        .a    (ax_p0),
        .size (bmpw_p0),
        .mode (mode_p0),
        .v    (ex),
        .clip (clip_x)
    );

    bitmap_edge #(
        .CORDW (CORDW)
    ) u_edge_y (
        .a    (ay_p0),
        .size (bmph_p0),
        .mode (mode_p0),
        .v    (ey),
        .clip (clip_y)
    );

    // Advance the valid flags; reset empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
        end
    end

    // Stage 1: widen by one bit so the offset add cannot overflow.
    always_ff @(posedge clk) begin
        if (adv) begin
            ax_p0   <= {x[CORDW-1], x} + {offx[CORDW-1], offx};
            ay_p0   <= {y[CORDW-1], y} + {offy[CORDW-1], offy};
            bmpw_p0 <= bmpw;
            bmph_p0 <= bmph;
            base_p0 <= base;
            mode_p0 <= edge_mode_t'(mode);
            tag_p0  <= in_tag;
        end
    end

    // Stage 2: edge mapping and a single registered multiply-add.
    always_ff @(posedge clk) begin
        if (adv) begin
            p_p1    <= PW'(ey) * PW'($unsigned(bmpw_p0)) + PW'(ex);
            clip_p1 <= clip_x | clip_y;
            base_p1 <= base_p0;
            tag_p1  <= tag_p0;
        end
    end

    // Stage 3: word address and pixel select, forced to zero on clip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            sel     <= '0;
            clip    <= 1'b0;
            out_tag <= '0;
        end else if (adv && vld_p1) begin
            addr    <= clip_p1 ? '0 : base_p1 + p_p1[SHIFT +: ADDRW];
            sel     <= clip_p1 ? '0 : (p_p1[SELW-1:0] & SEL_MASK);
            clip    <= clip_p1;
            out_tag <= tag_p1;
        end
    end

endmodule

// File: tb/tb_bitmap_addr_stream.sv
// Directed and randomized bench for bitmap_addr_stream at PIXW=4, WORDW=32.
module tb_bitmap_addr_stream;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] bmpw, bmph, x, y, offx, offy;
    logic        [23:0] base;
    logic        [1:0]  mode;
    logic               in_valid, in_ready;
    logic        [7:0]  in_tag;
    logic               out_valid, out_ready;
    logic        [23:0] addr;
    logic        [2:0]  sel;
    logic               clip;
    logic        [7:0]  out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] a;
        logic [2:0]  s;
        logic        c;
        logic [7:0]  t;
    } exp_t;

    exp_t q[$];

    bitmap_addr_stream #(
        .CORDW (16), .ADDRW (24), .PIXW (4), .WORDW (32), .TAGW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bmpw      (bmpw),
        .bmph      (bmph),
        .base      (base),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .offx      (offx),
        .offy      (offy),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr      (addr),
        .sel       (sel),
        .clip      (clip),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent per-axis edge model.
    function automatic void edge_ref(input int a, input int s, input int m,
                                     output int v, output bit c);
        v = 0;
        c = 1'b0;
        if (m == 1) begin
            if (a < -s || a >= 2 * s) c = 1'b1;
            else if (a < 0)           v = a + s;
            else if (a >= s)          v = a - s;
            else                      v = a;
        end else if (m == 2) begin
            v = (a < 0) ? 0 : ((a >= s) ? s - 1 : a);
        end else begin
            c = (a < 0) || (a >= s);
            v = c ? 0 : a;
        end
    endfunction

    function automatic void ref_model(input int xx, input int yy, input int ox, input int oy,
                                      input int w, input int h, input int m, input int b,
                                      output logic [23:0] ea, output logic [2:0] es,
                                      output logic ec);
        int vx, vy, p;
        bit cx, cy;
        edge_ref(xx + ox, w, m, vx, cx);
        edge_ref(yy + oy, h, m, vy, cy);
        ec = cx | cy;
        if (ec) begin
            ea = '0;
            es = '0;
        end else begin
            p  = vy * w + vx;
            ea = 24'(b + (p >>> 3));
            es = 3'(p & 7);
        end
    endfunction

    // Issue one request into an idle pipe and wait for its result.
    task automatic single(input int m, input int xx, input int yy, input int ox, input int oy,
                          input logic [7:0] t, output int lat, output logic [23:0] oa,
                          output logic [2:0] os, output logic oc, output logic [7:0] ot);
        mode      = 2'(m);
        x         = 16'(xx);
        y         = 16'(yy);
        offx      = 16'(ox);
        offy      = 16'(oy);
        in_tag    = t;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            tick();
        end
        oa = addr;
        os = sel;
        oc = clip;
        ot = out_tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (addr !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
        checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", clip); end
        checks++; if (out_tag !== 8'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_clip();
        int lat; logic [23:0] a; logic [2:0] s; logic c; logic [7:0] t;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000;
        single(0, 10, 2, 0, 0, 8'h11, lat, a, s, c, t);
        checks++; if (lat !== 3) begin errors++; $display("FAIL clip_latency: got %0d want 3", lat); end
        checks++; if ({a, s, c, t} !== {24'h1051, 3'd2, 1'b0, 8'h11})
            begin errors++; $display("FAIL clip_basic: got %h/%0d/%b/%h want 1051/2/0/11", a, s, c, t); end
        single(0, 320, 0, 0, 0, 8'h12, lat, a, s, c, t);
        checks++; if ({a, s, c, t} !== {24'h0, 3'd0, 1'b1, 8'h12})
            begin errors++; $display("FAIL clip_right_edge: got %h/%0d/%b/%h want 0/0/1/12", a, s, c, t); end
        single(0, 5, 1, 5, 1, 8'h13, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h1051, 3'd2, 1'b0})
            begin errors++; $display("FAIL clip_offset: got %h/%0d/%b want 1051/2/0", a, s, c); end
        single(3, 10, 2, 0, 0, 8'h14, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h1051, 3'd2, 1'b0})
            begin errors++; $display("FAIL clip_mode3: got %h/%0d/%b want 1051/2/0", a, s, c); end
        single(0, 0, -1, 0, 0, 8'h15, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h0, 3'd0, 1'b1})
            begin errors++; $display("FAIL clip_negative_y: got %h/%0d/%b want 0/0/1", a, s, c); end
        base = 24'hFFFFFF;
        single(0, 8, 0, 0, 0, 8'h16, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h000000, 3'd0, 1'b0})
            begin errors++; $display("FAIL clip_addr_wrap: got %h/%0d/%b want 000000/0/0", a, s, c); end
        base = 24'h1000;
    endtask

    task automatic test_wrap();
        int lat; logic [23:0] a; logic [2:0] s; logic c; logic [7:0] t;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000;
        single(1, -1, 0, 0, 0, 8'h21, lat, a, s, c, t);
        checks++; if ({a, s, c, t} !== {24'h1027, 3'd7, 1'b0, 8'h21})
            begin errors++; $display("FAIL wrap_neg_x: got %h/%0d/%b/%h want 1027/7/0/21", a, s, c, t); end
        single(1, 700, 0, 0, 0, 8'h22, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h0, 3'd0, 1'b1})
            begin errors++; $display("FAIL wrap_far_x: got %h/%0d/%b want 0/0/1", a, s, c); end
        single(1, 0, -2, 0, 0, 8'h23, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h2BD0, 3'd0, 1'b0})
            begin errors++; $display("FAIL wrap_neg_y: got %h/%0d/%b want 2bd0/0/0", a, s, c); end
        single(1, 320, 1, 0, 0, 8'h24, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h1028, 3'd0, 1'b0})
            begin errors++; $display("FAIL wrap_x_eq_w: got %h/%0d/%b want 1028/0/0", a, s, c); end
        single(1, -320, 0, 0, 0, 8'h25, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h1000, 3'd0, 1'b0})
            begin errors++; $display("FAIL wrap_x_eq_negw: got %h/%0d/%b want 1000/0/0", a, s, c); end
        single(1, -321, 0, 0, 0, 8'h26, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h0, 3'd0, 1'b1})
            begin errors++; $display("FAIL wrap_below_negw: got %h/%0d/%b want 0/0/1", a, s, c); end
    endtask

    task automatic test_clamp();
        int lat; logic [23:0] a; logic [2:0] s; logic c; logic [7:0] t;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000;
        single(2, 400, 200, 0, 0, 8'h31, lat, a, s, c, t);
        checks++; if ({a, s, c, t} !== {24'h2C1F, 3'd7, 1'b0, 8'h31})
            begin errors++; $display("FAIL clamp_high: got %h/%0d/%b/%h want 2c1f/7/0/31", a, s, c, t); end
        single(2, -5, -5, 0, 0, 8'h32, lat, a, s, c, t);
        checks++; if ({a, s, c} !== {24'h1000, 3'd0, 1'b0})
            begin errors++; $display("FAIL clamp_low: got %h/%0d/%b want 1000/0/0", a, s, c); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        logic [23:0] sa; logic [2:0] ss; logic [7:0] st;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000;
        mode = 2'd0; y = 16'sd0; offx = 16'sd0; offy = 16'sd0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (idx < 5);
            x        = 16'(9 * (idx + 1));
            in_tag   = 8'(8'hA1 + idx);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        sa = addr; ss = sel; st = out_tag;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({addr, sel, out_tag} !== {sa, ss, st})
                begin errors++; $display("FAIL bp_stable: got %h/%0d/%h want %h/%0d/%h", addr, sel, out_tag, sa, ss, st); end
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            in_valid = (idx < 5);
            x        = 16'(9 * (idx + 1));
            in_tag   = 8'(8'hA1 + idx);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if ({addr, sel, clip, out_tag} !== {24'(24'h1001 + got), 3'(got + 1), 1'b0, 8'(8'hA1 + got)}) begin
                    errors++;
                    $display("FAIL bp_result%0d: got %h/%0d/%b/%h want %h/%0d/0/%h", got, addr, sel, clip, out_tag,
                             24'h1001 + got, got + 1, 8'hA1 + got);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000; mode = 2'd0;
        out_ready = 1'b1;
        in_valid = 1'b1; x = 16'sd10; y = 16'sd2; in_tag = 8'h51;
        tick();
        x = 16'sd11; in_tag = 8'h52;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, addr, out_tag} !== {1'b0, 24'h0, 8'h0})
            begin errors++; $display("FAIL midrst_clear: got %b/%h/%h want 0/0/0", out_valid, addr, out_tag); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_stale: got %0d results want 0", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        bit pend = 1'b0;
        exp_t e, f;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4000 && (sent < 200 || q.size() > 0); cyc++) begin
            if (!pend && sent < 200 && $urandom_range(0, 3) != 0) begin
                mode   = 2'($urandom_range(0, 3));
                bmpw   = 16'($urandom_range(1, 400));
                bmph   = 16'($urandom_range(1, 300));
                base   = 24'($urandom);
                x      = 16'(int'($urandom_range(0, 1800)) - 900);
                y      = 16'(int'($urandom_range(0, 1400)) - 700);
                offx   = 16'(int'($urandom_range(0, 100)) - 50);
                offy   = 16'(int'($urandom_range(0, 100)) - 50);
                in_tag = 8'(sent);
                pend   = 1'b1;
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: got result tag %h want none", out_tag);
                end else begin
                    f = q.pop_front();
                    if ({addr, sel, clip, out_tag} !== {f.a, f.s, f.c, f.t}) begin
                        errors++;
                        $display("FAIL rand_result: got %h/%0d/%b/%h want %h/%0d/%b/%h",
                                 addr, sel, clip, out_tag, f.a, f.s, f.c, f.t);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_model(int'(x), int'(y), int'(offx), int'(offy), int'(bmpw), int'(bmph),
                          int'(mode), int'(base), e.a, e.s, e.c);
                e.t = in_tag;
                q.push_back(e);
                sent++;
                pend = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (sent !== 200) begin errors++; $display("FAIL rand_sent: got %0d want 200", sent); end
        checks++; if (got !== 200) begin errors++; $display("FAIL rand_received: got %0d want 200", got); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bmpw = 16'sd320; bmph = 16'sd180; base = 24'h1000; mode = 2'd0;
        x = '0; y = '0; offx = '0; offy = '0; in_tag = '0;
        test_reset();
        test_clip();
        test_wrap();
        test_clamp();
        tick();
        tick();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
